// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding types and constants for the instruction encoder slice.
// Holds immediate-source and FSM enums plus the sign-extension fit helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } imm_src_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } enc_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_word_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;

    // True when v[31:lsb] is all zeros or all ones, i.e. v fits a (lsb+1)-bit signed field.
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] hi;
        logic [31:0] ones;
        hi   = v >> lsb;
        ones = 32'hFFFF_FFFF >> lsb;
        return (hi == '0) || (hi == ones);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Control, input-stream and output-stream bundle of the instruction encoder.
// master = program loader / test driver, slave = instr_encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  run_len;

    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_imm_source;
    logic [31:0]       in_imm;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    logic              busy;
    logic              done;
    logic              err_flag;

    modport master (
        output start, base_addr, run_len,
        output in_valid, in_imm_source, in_imm, in_opcode, in_funct3, in_rd, in_rs1, in_rs2,
        input  in_ready,
        input  out_valid, out_instr, out_addr, out_err,
        output out_ready,
        input  busy, done, err_flag
    );

    modport slave (
        input  start, base_addr, run_len,
        input  in_valid, in_imm_source, in_imm, in_opcode, in_funct3, in_rd, in_rs1, in_rs2,
        output in_ready,
        output out_valid, out_instr, out_addr, out_err,
        input  out_ready,
        output busy, done, err_flag
    );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational repacking of a byte immediate into I/S/B instruction bit positions.
// INSTR_ENCODER_RANGE_CHECK_EN flags immediates that do not fit the chosen format.
module imm_pack
    import riscv_pkg::*;
(
    input  logic [1:0]  src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output enc_word_t   word
);

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK_EN = 1'b1;
`else
    localparam bit RANGE_CHECK_EN = 1'b0;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every field; no latch can be inferred.
        word.instr = NOP_INSTR;
        word.err   = 1'b1;
        case (src)
            IMM_I: begin
                word.instr = {imm[11:0], rs1, funct3, rd, opcode};
                word.err   = RANGE_CHECK_EN && !sext_fits(imm, 11);
            end
            IMM_S: begin
                word.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                word.err   = RANGE_CHECK_EN && !sext_fits(imm, 11);
            end
            IMM_B: begin
                word.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                word.err   = RANGE_CHECK_EN && (!sext_fits(imm, 12) || imm[0]);
            end
            default: begin
                word.instr = NOP_INSTR;
                word.err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: run-control FSM, word counter, address counter and
// a one-deep output register in front of instruction memory.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    instr_encoder_if.slave bus
);

    enc_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, acc_q;
    logic [ADDR_W-1:0] addr_q;
    logic              out_valid_q;
    logic              err_flag_q;
    enc_word_t         word_q, word_d;

    logic start_fire, in_ready_c, in_fire, out_fire;

    imm_pack u_imm_pack (
        .src    (bus.in_imm_source),
        .imm    (bus.in_imm),
        .opcode (bus.in_opcode),
        .funct3 (bus.in_funct3),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .word   (word_d)
    );

    assign start_fire = bus.start && (state_q == ST_IDLE);
    assign in_fire    = bus.in_valid && in_ready_c;
    assign out_fire   = out_valid_q && bus.out_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start)     state_d = ST_RUN;
            ST_RUN:   if (acc_q == len_q) state_d = ST_FLUSH;
            ST_FLUSH: if (!out_valid_q)  state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c = (state_q == ST_RUN) && (acc_q < len_q) && (!out_valid_q || bus.out_ready);
        bus.busy   = (state_q != ST_IDLE);
        bus.done   = (state_q == ST_DONE);
    end

    // Address tracks the word currently presented; it advances only when that word leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            err_flag_q <= 1'b0;
        end else if (start_fire) begin
            len_q      <= bus.run_len;
            acc_q      <= '0;
            addr_q     <= bus.base_addr;
            err_flag_q <= 1'b0;
        end else begin
            if (in_fire)  acc_q <= acc_q + LEN_W'(1);
            if (out_fire) begin
                addr_q <= addr_q + ADDR_W'(4);
                if (word_q.err) err_flag_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            word_q      <= '0;
        end else if (in_fire) begin
            out_valid_q <= 1'b1;
            word_q      <= word_d;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
            word_q      <= '0;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = word_q.instr;
    assign bus.out_err   = word_q.err;
    assign bus.out_addr  = addr_q;
    assign bus.err_flag  = err_flag_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized runs scored
// against an arithmetic reference model of the encoding and addressing rules.
module tb_instr_encoder;
    import riscv_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
    instr_encoder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] instr; logic err; } exp_t;
    typedef struct {
        logic [1:0] src; logic [31:0] imm; logic [6:0] op; logic [2:0] f3;
        logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    } word_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoding: field placement by integer arithmetic, range by signed value.
    function automatic exp_t model_enc(input logic [1:0] src, input logic [31:0] imm,
                                       input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        int unsigned u, o, fu, d, a, b;
        int s;
        exp_t r;
        u = imm; s = imm; o = op; fu = f3; d = rd; a = rs1; b = rs2;
        r.err = 1'b0;
        case (src)
            2'd0: begin
                r.instr = ((u % 4096) << 20) + (a << 15) + (fu << 12) + (d << 7) + o;
                if (RC && (s < -2048 || s > 2047)) r.err = 1'b1;
            end
            2'd1: begin
                r.instr = (((u / 32) % 128) << 25) + (b << 20) + (a << 15) + (fu << 12)
                        + ((u % 32) << 7) + o;
                if (RC && (s < -2048 || s > 2047)) r.err = 1'b1;
            end
            2'd2: begin
                r.instr = (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25) + (b << 20)
                        + (a << 15) + (fu << 12) + (((u / 2) % 16) << 8)
                        + (((u / 2048) % 2) << 7) + o;
                if (RC && (s < -4096 || s > 4095 || (u % 2) == 1)) r.err = 1'b1;
            end
            default: begin
                r.instr = 32'h13;
                r.err   = 1'b1;
            end
        endcase
        return r;
    endfunction

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] m_addr;
    bit          m_eflag;
    int          done_cnt = 0;
    bit          start_real = 1'b0;
    logic [31:0] log_instr[$];
    logic [31:0] log_addr[$];
    logic        log_err[$];
    bit          prev_hold = 1'b0;
    logic [31:0] prev_instr, prev_addr;
    logic        prev_err;
    int          rdy_mode = 0;
    word_t       wl[$];

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Compare process: every emitted word is checked against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_addr    = '0;
            m_eflag   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("err_flag", bus.err_flag, m_eflag);
            if (prev_hold) begin
                check("hold_valid", bus.out_valid, 1'b1);
                check("hold_word", {bus.out_instr, bus.out_addr, bus.out_err},
                      {prev_instr, prev_addr, prev_err});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", bus.out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_instr", bus.out_instr, mon_e.instr);
                    check("out_addr", bus.out_addr, m_addr);
                    check("out_err", bus.out_err, mon_e.err);
                    m_eflag = m_eflag | mon_e.err;
                    m_addr  = m_addr + 32'd4;
                    log_instr.push_back(bus.out_instr);
                    log_addr.push_back(bus.out_addr);
                    log_err.push_back(bus.out_err);
                end
            end
            prev_hold  = bus.out_valid && !bus.out_ready;
            prev_instr = bus.out_instr;
            prev_addr  = bus.out_addr;
            prev_err   = bus.out_err;
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model_enc(bus.in_imm_source, bus.in_imm, bus.in_opcode,
                                          bus.in_funct3, bus.in_rd, bus.in_rs1, bus.in_rs2));
            if (bus.done) done_cnt++;
            if (bus.start && start_real) begin
                m_addr  = bus.base_addr;
                m_eflag = 1'b0;
            end
        end
    end

    task automatic drive_word(input word_t w);
        int n;
        bus.in_valid = 1'b1;
        bus.in_imm_source = w.src; bus.in_imm = w.imm; bus.in_opcode = w.op;
        bus.in_funct3 = w.f3; bus.in_rd = w.rd; bus.in_rs1 = w.rs1; bus.in_rs2 = w.rs2;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [15:0] len, input bit real_start);
        bus.start = 1'b1; bus.base_addr = base; bus.run_len = len; start_real = real_start;
        @(posedge clk); #1;
        bus.start = 1'b0; start_real = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        @(negedge clk);
        n = 1;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, bus.done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 1'b0);
        check({tag, "_idle"}, bus.busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_run(input logic [31:0] base, input int len, input int budget,
                          input int gap_max, input string tag);
        int d0;
        d0 = done_cnt;
        log_instr.delete(); log_addr.delete(); log_err.delete();
        start_run(base, len[15:0], 1'b1);
        foreach (wl[i]) begin
            drive_word(wl[i]);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
        wait_done(budget, tag);
        check({tag, "_count"}, log_instr.size(), len);
        check({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        word_t w;
        int n, d0, len;
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.run_len = '0;
        bus.in_valid = 1'b0; bus.in_imm_source = '0; bus.in_imm = '0; bus.in_opcode = '0;
        bus.in_funct3 = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_err", bus.out_err, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err_flag", bus.err_flag, 1'b0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_addr", bus.out_addr, 32'h0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // I-type, base 0
        wl.delete();
        wl.push_back('{2'd0, 32'hFFFF_FFFC, OP_IMM, 3'd0, 5'd6, 5'd9, 5'd0});
        do_run(32'h0, 1, 50, 0, "itype");
        check("itype_instr", log_instr[0], 32'hFFC4_8313);
        check("itype_addr", log_addr[0], 32'h0);
        check("itype_err", log_err[0], 1'b0);

        // S then B, back to back
        wl.delete();
        wl.push_back('{2'd1, 32'd8, OP_STORE, 3'd2, 5'd0, 5'd9, 5'd6});
        wl.push_back('{2'd2, 32'hFFFF_FFF8, OP_BRANCH, 3'd0, 5'd0, 5'd6, 5'd9});
        do_run(32'h100, 2, 50, 0, "sb");
        check("s_instr", log_instr[0], 32'h0064_A423);
        check("s_addr", log_addr[0], 32'h100);
        check("b_instr", log_instr[1], 32'hFE93_0CE3);
        check("b_addr", log_addr[1], 32'h104);

        // Out-of-range I immediate, then illegal source
        wl.delete();
        wl.push_back('{2'd0, 32'd2048, OP_IMM, 3'd0, 5'd2, 5'd1, 5'd0});
        do_run(32'h200, 1, 50, 0, "range");
        check("range_instr", log_instr[0], 32'h8000_8113);
        check("range_err", log_err[0], RC);
        check("range_err_flag", bus.err_flag, RC);
        wl.delete();
        wl.push_back('{2'd3, 32'h1234_5678, OP_LOAD, 3'd5, 5'd7, 5'd3, 5'd4});
        do_run(32'h300, 1, 50, 0, "illegal");
        check("illegal_instr", log_instr[0], 32'h0000_0013);
        check("illegal_err", log_err[0], 1'b1);
        check("illegal_err_flag", bus.err_flag, 1'b1);

        // Backpressure: output held for several cycles after the first word
        wl.delete();
        for (int i = 0; i < 3; i++) wl.push_back('{2'd0, 32'(i + 1), OP_IMM, 3'd0, 5'(i), 5'd1, 5'd0});
        log_instr.delete(); log_addr.delete(); log_err.delete();
        d0 = done_cnt;
        rdy_mode = 2;
        start_run(32'h0, 16'd3, 1'b1);
        fork
            begin
                foreach (wl[i]) drive_word(wl[i]);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!bus.out_valid && n < 50) begin n++; @(negedge clk); end
                check("bp_valid_seen", bus.out_valid, 1'b1);
                repeat (5) begin
                    check("bp_in_ready_low", bus.in_ready, 1'b0);
                    @(negedge clk);
                end
                rdy_mode = 0;
            end
        join
        wait_done(100, "bp");
        check("bp_count", log_instr.size(), 3);
        check("bp_addr0", log_addr[0], 32'h0);
        check("bp_addr1", log_addr[1], 32'h4);
        check("bp_addr2", log_addr[2], 32'h8);
        check("bp_done_once", done_cnt - d0, 1);

        // Zero-length run
        wl.delete();
        do_run(32'h500, 0, 3, 0, "zero_len");

        // Address wrap
        wl.delete();
        wl.push_back('{2'd0, 32'd5, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0});
        wl.push_back('{2'd0, 32'd6, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0});
        do_run(32'hFFFF_FFFC, 2, 50, 0, "wrap");
        check("wrap_addr0", log_addr[0], 32'hFFFF_FFFC);
        check("wrap_addr1", log_addr[1], 32'h0);

        // start while running is ignored
        log_instr.delete(); log_addr.delete(); log_err.delete();
        d0 = done_cnt;
        start_run(32'h40, 16'd3, 1'b1);
        drive_word('{2'd1, 32'd12, OP_STORE, 3'd2, 5'd0, 5'd2, 5'd3});
        start_run(32'h999, 16'd7, 1'b0);
        check("ign_busy", bus.busy, 1'b1);
        drive_word('{2'd1, 32'd16, OP_STORE, 3'd2, 5'd0, 5'd2, 5'd3});
        drive_word('{2'd2, 32'd20, OP_BRANCH, 3'd1, 5'd0, 5'd2, 5'd3});
        wait_done(100, "ign");
        check("ign_count", log_instr.size(), 3);
        check("ign_addr0", log_addr[0], 32'h40);
        check("ign_addr2", log_addr[2], 32'h48);
        check("ign_done_once", done_cnt - d0, 1);

        // Randomized runs with random backpressure and input gaps
        rdy_mode = 1;
        for (int r = 0; r < 10; r++) begin
            wl.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                w.src = 2'($urandom_range(0, 3));
                w.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8191)) - 32'd4096 : $urandom;
                w.op  = 7'($urandom); w.f3 = 3'($urandom);
                w.rd  = 5'($urandom); w.rs1 = 5'($urandom); w.rs2 = 5'($urandom);
                wl.push_back(w);
            end
            do_run({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, len, 1000, 2, "rand");
        end
        rdy_mode = 0;
        repeat (2) begin @(posedge clk); #1; end

        // Asynchronous reset with a word held in the output register
        rdy_mode = 2;
        start_run(32'h300, 16'd4, 1'b1);
        drive_word('{2'd0, 32'd7, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0});
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin n++; @(negedge clk); end
        check("mid_valid_before_rst", bus.out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_out_valid", bus.out_valid, 1'b0);
        check("mid_out_err", bus.out_err, 1'b0);
        check("mid_out_instr", bus.out_instr, 32'h0);
        check("mid_out_addr", bus.out_addr, 32'h0);
        check("mid_busy", bus.busy, 1'b0);
        check("mid_done", bus.done, 1'b0);
        check("mid_err_flag", bus.err_flag, 1'b0);
        check("mid_in_ready", bus.in_ready, 1'b0);
        d0 = done_cnt;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_no_done", done_cnt - d0, 0);
        check("mid_idle", bus.busy, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V instruction encoder: the inverse of the immediate sign-extension path. It accepts decoded fields and a 32-bit immediate, repacks the immediate into the I/S/B bit positions, and emits 32-bit instruction words with word addresses. It sits in the test/boot infrastructure in front of instruction memory and loads programs built from field-level descriptions. A small run-control FSM bounds each load to a programmed word count and reports completion.

## Interface
- `ADDR_W`, 32: width of the byte address counter.
- `LEN_W`, 16: width of the run length.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse, begins a run; ignored unless FSM is IDLE.
- `base_addr` in ADDR_W: byte address of the first word; sampled on `start`.
- `run_len` in LEN_W: number of words in the run; sampled on `start`; 0 is legal.
- `in_valid` / `in_ready` in/out 1: input handshake.
- `in_imm_source` in 2: 00 I, 01 S, 10 B, 11 illegal.
- `in_imm` in 32: signed byte immediate.
- `in_opcode` in 7, `in_funct3` in 3, `in_rd`/`in_rs1`/`in_rs2` in 5: instruction fields.
- `out_valid` / `out_ready` out/in 1: output handshake.
- `out_instr` out 32: encoded word.
- `out_addr` out ADDR_W: byte address of `out_instr`.
- `out_err` out 1: sideband error flag for this word.
- `busy` out 1: FSM not IDLE.
- `done` out 1: one-cycle pulse at run completion.
- `err_flag` out 1: sticky OR of every emitted `out_err`; cleared on accepted `start`.

## Operation
- Encoding, for fields `imm`, `rs2`, `rs1`, `f3`, `rd`, `op`:
  - I: `{imm[11:0], rs1, f3, rd, op}`.
  - S: `{imm[11:5], rs2, rs1, f3, imm[4:0], op}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}`.
  - Illegal source 11: `out_instr` = 32'h0000_0013 (NOP), `out_err` = 1 always.
- FSM states and transitions:
  - IDLE -> RUN on `start`. Latches the address and length, clears `err_flag`.
  - RUN -> FLUSH when the accepted-input count equals `run_len`; immediately if `run_len` = 0.
  - FLUSH -> DONE when the output register is empty.
  - DONE -> IDLE after one cycle; `done` = 1 in DONE only.
- `in_ready` = (state == RUN) && (accepted < run_len) && (!out_valid || out_ready).
- The output register loads on input handshake. It clears on output handshake when no new load occurs.
- Address: the first word uses `base_addr`. `+4` on each output handshake, wrapping modulo 2^ADDR_W.
- Simultaneous `start` while busy: ignored.

## Timing
- Latency: input handshake in cycle N gives `out_valid` in cycle N+1. Throughput is 1 word per cycle with `out_ready` held high.
- `out_valid` stays high with stable `out_instr`/`out_addr`/`out_err` until `out_ready`.
- Reset values:
  - `out_valid`, `out_err`, `done`, `busy`, `err_flag` = 0.
  - `out_instr`, `out_addr` = 0.
  - FSM = IDLE, counters = 0.
- Reset mid-run: the in-flight word is discarded, and no `done` is issued.

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined:
  - `out_err` = 1 when I/S imm[31:11] is not all-equal.
  - `out_err` = 1 when B imm[31:12] is not all-equal, or when B imm[0] = 1.
  - The word is still emitted, with truncated bits.
- Undefined: out-of-range immediates are truncated silently. `out_err` is set only for source 11.

## Structure
- Shared package `riscv_pkg`:
  - `imm_src_t` enum (IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10).
  - `NOP_INSTR` constant.
  - opcode constants.
  - FSM state enum `enc_state_t`.
- One natural sub-module, `imm_pack`: purely combinational. Maps source + fields to `{instr, err}`, including the range check under the macro. The top holds the FSM, counters and output register.

## Test plan
- I-type: imm=32'hFFFF_FFFC, rs1=9, rd=6, f3=0, op=7'h13, base 0 -> `out_instr`=32'hFFC4_8313, `out_addr`=0, `out_err`=0.
- S then B, run_len=2, base 32'h100:
  - S: imm=8, rs2=6, rs1=9, f3=2, op=7'h23 -> 32'h0064_A423 @ 32'h100.
  - B: imm=-8, rs1=6, rs2=9, f3=0, op=7'h63 -> 32'hFE93_0CE3 @ 32'h104.
  - One-cycle `done` after the second word.
- Range and illegal source:
  - I imm=2048 -> `out_err`=1 and `err_flag`=1 with the macro; `out_err`=0 and field 12'h800 without it.
  - Source 11 -> 32'h0000_0013 with `out_err`=1 in both builds.
- Backpressure: run_len=3, `out_ready` low for 5 cycles after the first word -> `in_ready` low, output held stable, no loss, addresses 0/4/8, exactly three words.
- Boundaries:
  - run_len=0 -> `done` within 3 cycles, no output.
  - base 32'hFFFF_FFFC with 2 words -> second address wraps to 0.
  - `start` during RUN is ignored.
- Reset asserted mid-run with `out_valid`=1 -> all outputs zero asynchronously, FSM IDLE, no `done`.
